// File: rtl/fifo_cdcc.sv
// Single-clock FWFT FIFO with valid/ready handshakes on both sides.
// Optional status outputs (fill level, sticky overflow) under FIFO_CDCC_STATUS_EN.
module fifo_cdcc #(
  parameter int unsigned INT_FIFO_WIDTH = 32,
  parameter int unsigned INT_FIFO_DEPTH = 256,
  localparam int unsigned PTR_BITS = $clog2(INT_FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INT_FIFO_WIDTH-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [INT_FIFO_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  input  logic                      i_dready
`ifdef FIFO_CDCC_STATUS_EN
  ,
  output logic [PTR_BITS:0]         o_fill_level,
  output logic                      o_overflow
`endif
);

  localparam logic [PTR_BITS:0] FullCount = (PTR_BITS + 1)'(INT_FIFO_DEPTH);

  logic [INT_FIFO_WIDTH-1:0] mem_q [INT_FIFO_DEPTH];
  logic [PTR_BITS-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]         count_q, count_d;
  logic                      rst_q;
  logic                      wr_fire, rd_fire;

  // rst_q holds o_ready low for the first cycle after reset release.
  always_comb begin
    o_ready      = (count_q != FullCount) & ~rst_q;
    o_data_valid = (count_q != '0);
    o_data       = o_data_valid ? mem_q[rd_ptr_q] : '0;
    wr_fire      = i_valid & o_ready;
    rd_fire      = o_data_valid & i_dready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

`ifdef FIFO_CDCC_STATUS_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (i_valid && (count_q == FullCount)) begin
      overflow_q <= 1'b1;
    end
  end

  always_comb begin
    o_fill_level = count_q;
    o_overflow   = overflow_q;
  end
`endif

endmodule

// File: tb/tb_fifo_cdcc.sv
// Randomized self-checking bench for fifo_cdcc against a queue-based reference model.
// Status outputs are checked when FIFO_CDCC_STATUS_EN is defined.
module tb_fifo_cdcc;

  localparam int W = 32;
  localparam int D = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  i_data;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  o_data;
  logic          o_data_valid;
  logic          i_dready;
`ifdef FIFO_CDCC_STATUS_EN
  logic [8:0]    o_fill_level;
  logic          o_overflow;
`endif

  always #5 clk = ~clk;

  fifo_cdcc #(
    .INT_FIFO_WIDTH(W),
    .INT_FIFO_DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .i_dready    (i_dready)
`ifdef FIFO_CDCC_STATUS_EN
    ,
    .o_fill_level(o_fill_level),
    .o_overflow  (o_overflow)
`endif
  );

  // Reference model: contents as a queue, plus the "one cycle after reset" flag.
  logic [W-1:0] q[$];
  bit           m_rstq;
  bit           m_ovf;
  int           n_checks;
  int           n_fail;

  function automatic logic exp_ready();
    return (q.size() != D) && !m_rstq;
  endfunction

  function automatic logic exp_valid();
    return q.size() != 0;
  endfunction

  function automatic logic [W-1:0] exp_data();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic step();
    int  sz;
    bit  wr, rd;
    @(posedge clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      m_rstq = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      wr = i_valid && (sz != D) && !m_rstq;
      rd = i_dready && (sz != 0);
      if (i_valid && sz == D) m_ovf = 1'b1;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(i_data);
      m_rstq = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_dready = 1'b0; i_data = '0;
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'($urandom); i_dready = 1'($urandom); i_data = $urandom;
      step();
      n_checks++;
      if ({o_ready, o_data_valid, o_data} !== {1'b0, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_outputs: cycle %0d got rdy=%b vld=%b data=%h, need 0/0/0",
                 i, o_ready, o_data_valid, o_data);
      end
    end
    rst = 1'b0; i_valid = 1'b0; i_dready = 1'b0;
    step();
    n_checks++;
    if (o_ready !== 1'b1 || o_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b, need 1/0", o_ready, o_data_valid);
    end
  endtask

  task automatic test_fill();
    i_dready = 1'b0;
    for (int k = 1; k <= D + 1; k++) begin
      i_valid = 1'b1; i_data = k;
      step();
      n_checks++;
      if ({o_ready, o_data_valid, o_data} !== {exp_ready(), exp_valid(), exp_data()}) begin
        n_fail++;
        $display("FAIL fill_cycle: word %0d got rdy=%b vld=%b data=%h, need %b/%b/%h", k,
                 o_ready, o_data_valid, o_data, exp_ready(), exp_valid(), exp_data());
      end
      n_checks++;
      if (o_data !== 32'd1 || o_data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_head: word %0d got data=%h vld=%b, need 1/1", k, o_data,
                 o_data_valid);
      end
    end
    i_valid = 1'b0;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full_ready: got %b, need 0", o_ready);
    end
  endtask

  task automatic test_drain();
    i_valid = 1'b0; i_dready = 1'b1;
    for (int k = 1; k <= D; k++) begin
      n_checks++;
      if (o_data !== W'(k) || o_data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_order: got data=%h vld=%b, need %h/1", o_data, o_data_valid, k);
      end
      step();
      if (k == 1) begin
        n_checks++;
        if (o_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_ready: got %b, need 1 after first read", o_ready);
        end
      end
    end
    i_dready = 1'b0;
    n_checks++;
    if (o_data_valid !== 1'b0 || o_data !== '0) begin
      n_fail++;
      $display("FAIL drain_empty: got vld=%b data=%h, need 0/0", o_data_valid, o_data);
    end
  endtask

  task automatic test_wrap();
    i_dready = 1'b0;
    for (int k = 0; k < 200; k++) begin
      i_valid = 1'b1; i_data = $urandom;
      step();
    end
    i_valid = 1'b0; i_dready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      n_checks++;
      if (o_data !== exp_data() || o_data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_first: read %0d got %h, need %h", k, o_data, exp_data());
      end
      step();
    end
    i_dready = 1'b0;
    for (int k = 0; k < D; k++) begin
      i_valid = 1'b1; i_data = 1000 + k;
      step();
    end
    i_valid = 1'b0; i_dready = 1'b1;
    for (int k = 0; k < D; k++) begin
      n_checks++;
      if (o_data !== W'(1000 + k) || o_data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_order: read %0d got %h vld=%b, need %h", k, o_data, o_data_valid,
                 1000 + k);
      end
      step();
    end
    i_dready = 1'b0;
    n_checks++;
    if (o_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_empty: got vld=%b, need 0", o_data_valid);
    end
  endtask

  task automatic test_concurrent();
    int n_out;
    i_dready = 1'b0;
    for (int k = 0; k < 128; k++) begin
      i_valid = 1'b1; i_data = $urandom;
      step();
    end
    i_dready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      i_data = $urandom;
      n_checks++;
      if ({o_ready, o_data_valid, o_data} !== {exp_ready(), exp_valid(), exp_data()}) begin
        n_fail++;
        $display("FAIL concurrent_cycle: %0d got rdy=%b vld=%b data=%h, need %b/%b/%h", k,
                 o_ready, o_data_valid, o_data, exp_ready(), exp_valid(), exp_data());
      end
      step();
    end
    i_valid = 1'b0;
    n_out = 0;
    for (int k = 0; k < 300 && o_data_valid === 1'b1; k++) begin
      n_checks++;
      if (o_data !== exp_data()) begin
        n_fail++;
        $display("FAIL concurrent_drain: got %h, need %h", o_data, exp_data());
      end
      n_out++;
      step();
    end
    i_dready = 1'b0;
    n_checks++;
    if (n_out != 128) begin
      n_fail++;
      $display("FAIL concurrent_count: drained %0d words, need 128", n_out);
    end
    i_valid = 1'b1; i_data = 32'hA5A5_A5A5;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_data !== 32'hA5A5_A5A5 || o_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_word: got %h vld=%b, need a5a5a5a5/1", o_data, o_data_valid);
    end
    i_dready = 1'b1;
    step();
    i_dready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pv, pr;
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      i_valid  = ($urandom_range(0, 99) < pv);
      i_dready = ($urandom_range(0, 99) < pr);
      i_data   = $urandom;
      step();
      n_checks++;
      if ({o_ready, o_data_valid, o_data} !== {exp_ready(), exp_valid(), exp_data()}) begin
        n_fail++;
        $display("FAIL random_cycle: %0d got rdy=%b vld=%b data=%h, need %b/%b/%h", k,
                 o_ready, o_data_valid, o_data, exp_ready(), exp_valid(), exp_data());
      end
    end
    i_valid = 1'b0; i_dready = 1'b0;
  endtask

  task automatic test_midreset();
    i_dready = 1'b0;
    while (q.size() < 100) begin
      i_valid = 1'b1; i_data = $urandom;
      step();
    end
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (o_data_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_edge: got vld=%b rdy=%b, need 0/0", o_data_valid, o_ready);
    end
    step();
    n_checks++;
    if (o_ready !== 1'b1 || o_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got rdy=%b vld=%b, need 1/0", o_ready, o_data_valid);
    end
    i_valid = 1'b1; i_data = 32'd7;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_data !== 32'd7 || o_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_first: got %h vld=%b, need 7/1", o_data, o_data_valid);
    end
    i_dready = 1'b1;
    step();
    i_dready = 1'b0;
  endtask

`ifdef FIFO_CDCC_STATUS_EN
  task automatic test_status();
    i_dready = 1'b0;
    for (int k = 0; k < D; k++) begin
      i_valid = 1'b1; i_data = $urandom;
      step();
      n_checks++;
      if (o_fill_level !== 9'(q.size()) || o_overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL status_fill: got lvl=%0d ovf=%b, need %0d/%b", o_fill_level, o_overflow,
                 q.size(), m_ovf);
      end
    end
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_overflow !== 1'b1 || o_fill_level !== 9'(D)) begin
      n_fail++;
      $display("FAIL status_overflow: got ovf=%b lvl=%0d, need 1/%0d", o_overflow, o_fill_level,
               D);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (o_overflow !== 1'b0 || o_fill_level !== 9'd0) begin
      n_fail++;
      $display("FAIL status_clear: got ovf=%b lvl=%0d, need 0/0", o_overflow, o_fill_level);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_rstq   = 1'b1;
    m_ovf    = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_concurrent();
    test_back_to_back();
    test_midreset();
`ifdef FIFO_CDCC_STATUS_EN
    test_status();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
